// File: rtl/rtc_host_if_if.sv
// rtl/rtc_host_if_if.sv - host I/O bus and time-set request bundle for rtc_host_if
interface rtc_host_if_if;
    logic [7:0]  io_addr;
    logic        io_wr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        set_req;
    logic [39:0] set_time;
    logic        busy;
    logic        done;

    modport master (
        output io_addr, io_wr, io_wdata, set_req, set_time,
        input  io_rdata, busy, done
    );

    modport slave (
        input  io_addr, io_wr, io_wdata, set_req, set_time,
        output io_rdata, busy, done
    );
endinterface

// File: rtl/rtc_host_if.sv
// rtl/rtc_host_if.sv - Z80 port decode, RTC serial line drive and autonomous time-set sequencer
module rtc_host_if #(
    parameter logic [7:0]  PORT_CIN = 8'h10,
    parameter logic [7:0]  PORT_CTL = 8'h40,
    parameter int unsigned HOLD     = 4
) (
    input  logic         clk,
    input  logic         reset,
    rtc_host_if_if.slave bus,
    input  logic         cdata,
    output logic         cstb,
    output logic         cclk,
    output logic [3:0]   cin
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CLKH, S_CMD, S_STB, S_FIN} state_t;

    localparam logic [7:0] CNT_LAST = 8'(HOLD - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [5:0]  idx, idx_n;
    logic [39:0] cap, cap_n;
    logic [3:0]  sh_cin, sh_cin_n;
    logic        sh_stb, sh_stb_n, sh_clk, sh_clk_n;
    logic        cstb_n, cclk_n, done_n;
    logic [3:0]  cin_n;
    logic [5:0]  bit_pos;
    logic        phase_end;

    assign phase_end = (cnt == CNT_LAST);

    always_comb begin
        sh_cin_n = sh_cin;
        sh_stb_n = sh_stb;
        sh_clk_n = sh_clk;
        if (bus.io_wr) begin
            if (bus.io_addr == PORT_CIN) sh_cin_n = bus.io_wdata[3:0];
            if (bus.io_addr == PORT_CTL) begin
                sh_stb_n = bus.io_wdata[1];
                sh_clk_n = bus.io_wdata[2];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        cap_n   = cap;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.set_req) begin
                    cap_n   = bus.set_time;
                    idx_n   = 6'd0;
                    cnt_n   = 8'd0;
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_n = phase_end ? 8'd0 : cnt + 8'd1;
                if (phase_end) state_n = S_CLKH;
            end
            S_CLKH: begin
                cnt_n = phase_end ? 8'd0 : cnt + 8'd1;
                if (phase_end) begin
                    if (idx == 6'd39) begin
                        state_n = S_CMD;
                    end else begin
                        idx_n   = idx + 6'd1;
                        state_n = S_SETUP;
                    end
                end
            end
            S_CMD: begin
                cnt_n = phase_end ? 8'd0 : cnt + 8'd1;
                if (phase_end) state_n = S_STB;
            end
            S_STB: begin
                cnt_n = phase_end ? 8'd0 : cnt + 8'd1;
                if (phase_end) state_n = S_FIN;
            end
            S_FIN: begin
                cnt_n = phase_end ? 8'd0 : cnt + 8'd1;
                if (phase_end) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // The RTC expects each byte rotated left by 3, sent LSB first.
        bit_pos = {idx_n[5:3], idx_n[2:0] + 3'd5};

        cstb_n = sh_stb_n;
        cclk_n = sh_clk_n;
        cin_n  = sh_cin_n;
        case (state_n)
            S_SETUP: begin
                cstb_n = 1'b0;
                cclk_n = 1'b0;
                cin_n  = {3'b000, cap_n[bit_pos]};
            end
            S_CLKH: begin
                cstb_n = 1'b0;
                cclk_n = 1'b1;
                cin_n  = {3'b000, cap_n[bit_pos]};
            end
            S_CMD, S_FIN: begin
                cstb_n = 1'b0;
                cclk_n = 1'b0;
                cin_n  = 4'd2;
            end
            S_STB: begin
                cstb_n = 1'b1;
                cclk_n = 1'b0;
                cin_n  = 4'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= 8'd0;
            idx          <= 6'd0;
            cap          <= 40'd0;
            sh_cin       <= 4'd0;
            sh_stb       <= 1'b0;
            sh_clk       <= 1'b0;
            cstb         <= 1'b0;
            cclk         <= 1'b0;
            cin          <= 4'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.io_rdata <= 8'h00;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            cap          <= cap_n;
            sh_cin       <= sh_cin_n;
            sh_stb       <= sh_stb_n;
            sh_clk       <= sh_clk_n;
            cstb         <= cstb_n;
            cclk         <= cclk_n;
            cin          <= cin_n;
            bus.busy     <= (state_n != S_IDLE);
            bus.done     <= done_n;
            bus.io_rdata <= {3'b000, cdata, 4'b0000};
        end
    end
endmodule

// File: tb/tb_rtc_host_if.sv
// tb/tb_rtc_host_if.sv - self-checking bench for rtc_host_if
module tb_rtc_host_if;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cdata;
    logic       cstb, cclk;
    logic [3:0] cin;

    rtc_host_if_if bus();

    rtc_host_if #(.PORT_CIN(8'h10), .PORT_CTL(8'h40), .HOLD(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .cdata (cdata),
        .cstb  (cstb),
        .cclk  (cclk),
        .cin   (cin)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [3:0] m_cin;
    logic       m_stb, m_clk;

    logic q_bits[$];
    int   busy_cnt, done_cnt, stb_rises, stb_before, min_c0, c0_run, c2_run;
    logic [3:0] stb_cin, fall_cin;
    logic p_clk = 1'b0, p_stb = 1'b0, p_c0 = 1'b0;

    always @(negedge clk) begin
        c0_run = (cin[0] == p_c0) ? c0_run + 1 : 1;
        c2_run = (cin == 4'd2) ? c2_run + 1 : 0;
        if (bus.busy && cclk && !p_clk) begin
            q_bits.push_back(cin[0]);
            if (c0_run - 1 < min_c0) min_c0 = c0_run - 1;
        end
        if (bus.busy && cstb && !p_stb) begin
            stb_rises++;
            stb_cin    = cin;
            stb_before = c2_run - 1;
        end
        if (bus.busy && !cstb && p_stb) fall_cin = cin;
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
        p_clk = cclk;
        p_stb = cstb;
        p_c0  = cin[0];
    end

    task automatic clear_mon();
        q_bits.delete();
        busy_cnt = 0; done_cnt = 0; stb_rises = 0; stb_before = 0;
        stb_cin = 4'd0; fall_cin = 4'd0; min_c0 = 1000;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_write(input logic [7:0] addr, input logic [7:0] data);
        bus.io_wr    = 1'b1;
        bus.io_addr  = addr;
        bus.io_wdata = data;
        if (addr == 8'h10) m_cin = data[3:0];
        if (addr == 8'h40) begin
            m_stb = data[1];
            m_clk = data[2];
        end
    endtask

    function automatic logic [39:0] rand_time();
        logic [39:0] t;
        int s, m, h, d, mo;
        s = $urandom_range(0, 59); m = $urandom_range(0, 59); h = $urandom_range(0, 23);
        d = $urandom_range(1, 31); mo = $urandom_range(1, 12);
        t = 40'd0;
        t[3:0]   = 4'(s % 10); t[6:4]   = 3'(s / 10);
        t[11:8]  = 4'(m % 10); t[14:12] = 3'(m / 10);
        t[19:16] = 4'(h % 10); t[21:20] = 2'(h / 10);
        t[27:24] = 4'(d % 10); t[29:28] = 2'(d / 10);
        t[39:36] = 4'(mo);
        return t;
    endfunction

    // RTC-side view: regroup the shifted stream into bytes and undo the rotate-left-by-3.
    function automatic logic [39:0] rtc_decode();
        logic [39:0] r;
        logic [7:0]  v;
        r = 40'd0;
        if (q_bits.size() >= 40) begin
            for (int b = 0; b < 5; b++) begin
                for (int j = 0; j < 8; j++) v[j] = q_bits[8*b + j];
                r[8*b +: 8] = {v[2:0], v[7:3]};
            end
        end
        return r;
    endfunction

    // mode 0: quiet, 1: fixed overlap writes + second set_req, 2: random host noise
    task automatic run_set(input logic [39:0] t, input int mode, input string tag);
        bit seen, leak;
        logic [7:0] first8;
        clear_mon();
        bus.set_time = t;
        bus.set_req  = 1'b1;
        step();
        bus.set_req  = 1'b0;
        bus.set_time = {$urandom, $urandom}[39:0];
        check({tag, "_busy_start"}, bus.busy, 1'b1);
        check({tag, "_setup_lines"}, {cstb, cclk, cin[3:1]}, 5'b0);
        seen = 0;
        leak = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            bus.io_wr   = 1'b0;
            bus.set_req = 1'b0;
            if (mode == 1) begin
                if (k == 60) drive_write(8'h10, 8'h03);
                if (k == 61) drive_write(8'h40, 8'h04);
                if (k == 62) bus.set_req = 1'b1;
            end else if (mode == 2) begin
                case ($urandom_range(0, 7))
                    0: drive_write(8'h10, 8'($urandom));
                    1: drive_write(8'h40, 8'($urandom));
                    2: drive_write(8'($urandom), 8'($urandom));
                    3: bus.set_req = 1'b1;
                    default: ;
                endcase
            end
            step();
            if (bus.busy && cin[3:1] != 3'b000 && cin != 4'd2) leak = 1;
            if (bus.done) seen = 1;
        end
        bus.io_wr   = 1'b0;
        bus.set_req = 1'b0;
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_no_host_leak"}, leak, 1'b0);
        check({tag, "_done_lines"}, {bus.busy, cstb, cclk, cin}, {1'b0, m_stb, m_clk, m_cin});
        step();
        check({tag, "_rises"}, q_bits.size(), 40);
        check({tag, "_rtc_time"}, rtc_decode(), t);
        check({tag, "_busy_cycles"}, busy_cnt, 83 * HOLD);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_stb_pulses"}, stb_rises, 1);
        check({tag, "_stb_cin"}, {stb_cin, fall_cin}, 8'h22);
        check({tag, "_stb_setup_ok"}, stb_before >= HOLD, 1'b1);
        check({tag, "_cin_setup_ok"}, min_c0 >= HOLD, 1'b1);
        if (mode == 1) begin
            first8 = 8'h00;
            for (int j = 0; j < 8 && j < q_bits.size(); j++) first8[j] = q_bits[j];
            check({tag, "_first_byte"}, first8, 8'hB2);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] e_cin;
        logic       e_stb;
        logic       e_clk;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int  r;
        bit  hit;
        logic [7:0] rd_exp [3];
        logic       rd_in  [3];

        vecs[0] = '{1'b1, 8'h10, 8'hA5, 4'h5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h40, 8'h06, 4'h5, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 8'h41, 8'hFF, 4'h5, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h10, 8'h0A, 4'hA, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 8'h40, 8'h02, 4'hA, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h40, 8'h04, 4'hA, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 8'h11, 8'h0F, 4'hA, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h40, 8'hF9, 4'hA, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h10, 8'hF3, 4'h3, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h10, 8'h0C, 4'h3, 1'b0, 1'b0};

        reset = 1'b1; cdata = 1'b0;
        bus.io_wr = 1'b0; bus.io_addr = 8'h00; bus.io_wdata = 8'h00;
        bus.set_req = 1'b0; bus.set_time = 40'd0;
        m_cin = 4'd0; m_stb = 1'b0; m_clk = 1'b0;
        clear_mon();
        step(); step();
        check("reset_lines", {cstb, cclk, cin}, 6'd0);
        check("reset_busy_done", {bus.busy, bus.done}, 2'b00);
        check("reset_rdata", bus.io_rdata, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            bus.io_wr = vecs[i].wr; bus.io_addr = vecs[i].addr; bus.io_wdata = vecs[i].data;
            step();
            check($sformatf("host_vec%0d", i), {cstb, cclk, cin},
                  {vecs[i].e_stb, vecs[i].e_clk, vecs[i].e_cin});
        end
        bus.io_wr = 1'b0;
        m_cin = vecs[9].e_cin; m_stb = vecs[9].e_stb; m_clk = vecs[9].e_clk;

        rd_in[0] = 1'b0; rd_in[1] = 1'b1; rd_in[2] = 1'b0;
        rd_exp[0] = 8'h00; rd_exp[1] = 8'h10; rd_exp[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            cdata = rd_in[i];
            step();
            check($sformatf("rdata%0d", i), bus.io_rdata, rd_exp[i]);
        end
        cdata = 1'b1;
        #1 check("rdata_latency", bus.io_rdata, 8'h00);
        step();
        cdata = 1'b0;
        step();

        run_set(40'hC0_31_12_34_56, 1, "dir");
        for (int n = 0; n < 4; n++) run_set(rand_time(), 2, $sformatf("rnd%0d", n));

        drive_write(8'h10, 8'h0F); step();
        drive_write(8'h40, 8'h06); cdata = 1'b1; step();
        bus.io_wr = 1'b0; bus.set_time = rand_time(); bus.set_req = 1'b1; step();
        bus.set_req = 1'b0; step(); step();
        reset = 1'b1; drive_write(8'h10, 8'h07);
        step();
        check("midreset_lines1", {cstb, cclk, cin, bus.busy, bus.done}, 8'd0);
        step();
        check("midreset_lines2", {cstb, cclk, cin, bus.busy, bus.done}, 8'd0);
        check("midreset_rdata", bus.io_rdata, 8'h00);
        reset = 1'b0; bus.io_wr = 1'b0; cdata = 1'b0;
        m_cin = 4'd0; m_stb = 1'b0; m_clk = 1'b0;
        step();

        clear_mon();
        bus.set_time = 40'hC0_31_12_34_56; bus.set_req = 1'b1; step();
        bus.set_req = 1'b0;
        r = 0; hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            if (cclk && bus.busy) begin
                step();
                if (!cclk) r++;
            end else begin
                step();
            end
            if (cclk && r == 19) hit = 1;
        end
        check("abort_reached_clkh20", hit, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        check("abort_lines", {bus.busy, cclk, cstb}, 3'b000);
        for (int k = 0; k < 400; k++) step();
        check("abort_no_stb", stb_rises, 0);
        check("abort_no_done", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
